// File: rtl/bnn_upsample2x_stream.sv
// Streaming 2x nearest-neighbour binary upsampler.
// Each accepted input row of IN_W bits is expanded so that every column is
// duplicated horizontally, and the expanded row is emitted twice (vertical
// duplication), giving a 2*IN_H x 2*IN_W frame from an IN_H x IN_W one.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input row handshake
//   in_row[IN_W]           pooled binary row, bit j = column j
//   in_last                final row of the input frame
//   out_valid/out_ready    output row handshake
//   out_row[2*IN_W]        expanded row
//   out_last               final output row of the frame
//   frame_err              sticky: in_last disagreed with the IN_H row count
module bnn_upsample2x_stream #(
  parameter int unsigned IN_W  = 13,
  parameter int unsigned IN_H  = 13,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_row,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*IN_W-1:0] out_row,
  output logic              out_last,
  output logic              frame_err
);

  localparam int unsigned OUT_W = 2 * IN_W;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t             r_state;
  logic [OUT_W-1:0]   r_row;
  logic               r_blast;
  logic               r_out_valid;
  logic               r_out_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_frame_err;

  logic [OUT_W-1:0]   w_row_x;
  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_cnt_wrap;

  // Horizontal duplication: column j lands on output columns 2j and 2j+1.
  always_comb begin
    w_row_x = '0;
    for (int j = 0; j < int'(IN_W); j++) begin
      w_row_x[2*j]   = in_row[j];
      w_row_x[2*j+1] = in_row[j];
    end
  end

  // A new row is taken when empty, or while the second copy is leaving,
  // which keeps out_valid continuously high at full rate.
  assign w_in_ready = (r_state == S_EMPTY) || ((r_state == S_SECOND) && out_ready);
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_cnt_wrap = (r_cnt == CNT_W'(IN_H - 1));

  // Copy sequencer: row register, buffered last flag and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_row       <= '0;
      r_blast     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (in_valid) begin
            r_row       <= w_row_x;
            r_blast     <= in_last;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= S_FIRST;
          end
        end
        S_FIRST: begin
          if (out_ready) begin
            r_out_last <= r_blast;
            r_state    <= S_SECOND;
          end
        end
        S_SECOND: begin
          if (out_ready) begin
            r_out_last <= 1'b0;
            if (in_valid) begin
              r_row   <= w_row_x;
              r_blast <= in_last;
              r_state <= S_FIRST;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= S_EMPTY;
            end
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_state     <= S_EMPTY;
        end
      endcase
    end
  end

  // Input row counter and sticky framing check; framing itself follows in_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else if (w_in_fire) begin
      if (in_last || w_cnt_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (in_last != w_cnt_wrap) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_row   = r_row;
  assign out_last  = r_out_last;
  assign frame_err = r_frame_err;

endmodule
